// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state codes,
// ALU opcode constants and default widths.
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 3;

    // FSM state codes, also driven onto the LED state port.
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // ALU opcodes.
    localparam logic [2:0] OP_NOT     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_AND     = 3'b011;
    localparam logic [2:0] OP_MUL4    = 3'b100;
    localparam logic [2:0] OP_ADD     = 3'b101;
    localparam logic [2:0] OP_SUB     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

endpackage

// File: rtl/alu_result_reg.sv
// Result register with valid/ready output handshake. Once valid is set the
// stored result cannot change until the downstream transfer completes.
module alu_result_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_data,
    input  logic             ready,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             fire
);

    logic [WIDTH-1:0] result_reg;
    logic             valid_reg;

    // Capture a new result, or retire the held one when downstream takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (clear) begin
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (capture && !valid_reg) begin
            result_reg <= capture_data;
            valid_reg  <= 1'b1;
        end else if (valid_reg && ready) begin
            valid_reg  <= 1'b0;
        end
    end

    assign result = result_reg;
    assign valid  = valid_reg;
    assign fire   = valid_reg & ready;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequences operand A, operand B and opcode off a shared switch bus into the
// ALU, then captures and offers the ALU result downstream.
// Optional build macro: ALU_SEQ_ACCUM_EN -- each accepted result is fed back
// as operand A and the sequence restarts at operand B (accumulator mode).
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   opcode,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             err,
    output logic [2:0]       state
);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [OPW-1:0]   opcode_reg;
    logic             err_reg;

    logic             capture;
    logic [WIDTH-1:0] exec_value;
    logic             fire;

    // An undefined opcode yields a zero result whatever the ALU returns.
    assign capture    = (state_reg == S_EXEC);
    assign exec_value = err_reg ? '0 : alu_out;

    alu_result_reg #(
        .WIDTH (WIDTH)
    ) u_result (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .capture      (capture),
        .capture_data (exec_value),
        .ready        (result_ready),
        .result       (result),
        .valid        (result_valid),
        .fire         (fire)
    );

    // Operand/opcode capture FSM; load is only honoured in the three input states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_A;
            a_reg      <= '0;
            b_reg      <= '0;
            opcode_reg <= '0;
            err_reg    <= 1'b0;
        end else if (clear) begin
            state_reg  <= S_A;
            a_reg      <= '0;
            b_reg      <= '0;
            opcode_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_A: begin
                    if (load) begin
                        a_reg     <= din;
                        err_reg   <= 1'b0;
                        state_reg <= S_B;
                    end
                end
                S_B: begin
                    if (load) begin
                        b_reg     <= din;
                        state_reg <= S_OP;
                    end
                end
                S_OP: begin
                    if (load) begin
                        opcode_reg <= din[OPW-1:0];
                        err_reg    <= &din[OPW-1:0];
                        state_reg  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_reg <= S_HOLD;
                end
                S_HOLD: begin
                    if (fire) begin
`ifdef ALU_SEQ_ACCUM_EN
                        a_reg     <= result;
                        state_reg <= S_B;
`else
                        state_reg <= S_A;
`endif
                    end
                end
                default: begin
                    state_reg <= S_A;
                end
            endcase
        end
    end

    assign A      = a_reg;
    assign B      = b_reg;
    assign opcode = opcode_reg;
    assign err    = err_reg;
    assign state  = state_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: the sequencer drives a behavioural ALU
// and every output is checked each cycle against a transaction-level model.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       load;
    logic       clear;
    logic [7:0] alu_out;
    logic [7:0] dut_a;
    logic [7:0] dut_b;
    logic [2:0] dut_op;
    logic [7:0] dut_result;
    logic       dut_valid;
    logic       result_ready;
    logic       dut_err;
    logic [2:0] dut_state;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_operand_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .load         (load),
        .clear        (clear),
        .alu_out      (alu_out),
        .A            (dut_a),
        .B            (dut_b),
        .opcode       (dut_op),
        .result       (dut_result),
        .result_valid (dut_valid),
        .result_ready (result_ready),
        .err          (dut_err),
        .state        (dut_state)
    );

    // Behavioural 8-bit ALU.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a & b;
            3'd4:    return {4'b0, a[3:0]} * {4'b0, b[3:0]};
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_out = alu_f(dut_a, dut_b, dut_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: step = how many of A/B/op have been taken, plus result phase.
    int         m_step;   // 0=want A,1=want B,2=want op,3=computing,4=offering
    logic [7:0] m_a, m_b, m_res;
    logic [2:0] m_op;
    logic       m_valid, m_err;

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_valid = 0; m_err = 0;
        end else if (m_step == 0) begin
            if (load) begin m_a = din; m_err = 0; m_step = 1; end
        end else if (m_step == 1) begin
            if (load) begin m_b = din; m_step = 2; end
        end else if (m_step == 2) begin
            if (load) begin m_op = din[2:0]; m_err = (din[2:0] == 3'b111); m_step = 3; end
        end else if (m_step == 3) begin
            m_res = m_err ? 8'h00 : alu_f(m_a, m_b, m_op);
            m_valid = 1; m_step = 4;
        end else if (result_ready) begin
            $display("TXN A=%02h B=%02h op=%0d result=%02h err=%0b", m_a, m_b, m_op, m_res, m_err);
            m_valid = 0;
`ifdef ALU_SEQ_ACCUM_EN
            m_a = m_res; m_step = 1;
`else
            m_step = 0;
`endif
        end
    end

    // Single compare process: all outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",  dut_state,  m_step);
            chk("A",      dut_a,      m_a);
            chk("B",      dut_b,      m_b);
            chk("opcode", dut_op,     m_op);
            chk("result", dut_result, m_res);
            chk("valid",  dut_valid,  m_valid);
            chk("err",    dut_err,    m_err);
        end
    end

    task automatic do_load(input logic [7:0] v);
        din = v; load = 1'b1;
        @(negedge clk);
        load = 1'b0; din = 8'($urandom);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    // Run one full operation and check the result arrives two cycles after the op load.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp_res, input logic exp_err);
        do_clear();
        do_load(a);
        do_load(b);
        do_load(op);
        chk({name, "_exec_state"}, dut_state, 3);
        chk({name, "_valid_early"}, dut_valid, 0);
        chk({name, "_err"}, dut_err, exp_err);
        @(negedge clk);
        chk({name, "_valid"}, dut_valid, 1);
        chk({name, "_result"}, dut_result, exp_res);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; clear = 1'b0; din = 8'h00; result_ready = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_state", dut_state, 0);
        chk("reset_valid", dut_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add
        run_op("add", 8'h0C, 8'h05, 8'h05, 8'h11, 1'b0);
        chk("add_opcode", dut_op, 3'b101);
        accept();
        chk("add_valid_drop", dut_valid, 0);
`ifdef ALU_SEQ_ACCUM_EN
        chk("acc_a", dut_a, 8'h11);
        chk("acc_state", dut_state, 1);
        do_load(8'h01);
        do_load(8'h05);
        @(negedge clk);
        chk("acc_result", dut_result, 8'h12);
        accept();
`else
        chk("add_state_ret", dut_state, 0);
`endif

        // Subtract wrap and 4x4 multiply
        run_op("sub", 8'h03, 8'h05, 8'h06, 8'hFE, 1'b0);
        accept();
        run_op("mul", 8'hFF, 8'hF3, 8'h04, 8'h2D, 1'b0);
        accept();

        // Illegal opcode
        run_op("ill", 8'h03, 8'h05, 8'hFF, 8'h00, 1'b1);
        chk("ill_opcode", dut_op, 3'b111);
        accept();
`ifndef ALU_SEQ_ACCUM_EN
        do_load(8'h20);
        chk("ill_err_cleared", dut_err, 0);
`endif

        // Backpressure with load pulses toggling
        run_op("bp", 8'h09, 8'h07, 8'h03, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            load = ~load; din = 8'($urandom);
            @(negedge clk);
            chk("bp_state", dut_state, 4);
            chk("bp_result", dut_result, 8'h01);
            chk("bp_valid", dut_valid, 1);
        end
        load = 1'b0;
        accept();
        chk("bp_valid_drop", dut_valid, 0);
`ifdef ALU_SEQ_ACCUM_EN
        chk("bp_state_ret", dut_state, 1);
`else
        chk("bp_state_ret", dut_state, 0);
`endif

        // Clear mid-operation, and clear beating load
        do_clear();
        do_load(8'h44);
        chk("clr_pre_state", dut_state, 1);
        do_clear();
        chk("clr_state", dut_state, 0);
        chk("clr_a", dut_a, 8'h00);
        chk("clr_valid", dut_valid, 0);
        clear = 1'b1; load = 1'b1; din = 8'h55;
        @(negedge clk);
        clear = 1'b0; load = 1'b0;
        chk("clr_load_state", dut_state, 0);
        chk("clr_load_a", dut_a, 8'h00);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            clear        = ($urandom_range(0, 39) == 0);
            load         = 1'($urandom_range(0, 1));
            din          = 8'($urandom);
            result_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        rst_n = 1'b1; clear = 1'b0; load = 1'b0; result_ready = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
